asic_iopoc_seq: RTL and testbench
=================================

# asic_iopoc_seq

Parametrised IO-ring power-on-control (POC) sequencer for the sky130 pad ring. It drives one `poc` line per IO power bank and releases the banks in order, one bank at a time. A bank is released only after its `vddio` level detector reports good and a settle interval has elapsed. On loss of power or on a disable request, all banks are forced back into the safe state at once. It sits beside the IO power pads and feeds their `poc` pins; `ready` gates core-side IO enables.

## Interface
Parameters:
- `NBANKS`, 4: number of IO power banks; legal range 1–16.
- `SETTLE`, 16: cycles between a bank's good detection and release of its `poc`; must be ≥ 1.
- `TIMEOUT`, 1024: maximum cycles to wait for a bank's good indication; must be > `SETTLE`.
- `FILT`, 4: consecutive stable samples required by the glitch filter (used only when the filter is compiled in).

Ports:
- `clk`, in, 1: sequencer clock.
- `nreset`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: power-up request, level-sensitive.
- `vddio_good`, in, `NBANKS`: per-bank level detector outputs; asynchronous to `clk`.
- `poc`, out, `NBANKS`: 1 = pad bank held in the safe state. Reset value: all ones.
- `ready`, out, 1: all banks released. Reset value: 0.
- `fault`, out, 1: timeout or power loss occurred; sticky. Reset value: 0.
- `fault_bank`, out, `$clog2(NBANKS)` (min 1): index of the faulting bank. Reset value: 0.

## Operation
- Every `vddio_good` bit passes through a 2-flop synchroniser to produce `good_s[i]`.
- States:
  - IDLE: all `poc` = 1. Exits to WAIT with bank index `idx` = 0 on `en` = 1 && `fault` = 0.
  - WAIT(idx):
    - If `good_s[idx]`: load counter with `SETTLE`, go to SETTLE.
    - Else, if the counter reaches `TIMEOUT`: set `fault`, set `fault_bank` = `idx`, go to FAULT.
  - SETTLE(idx):
    - Counter decrements; at 0, clear `poc[idx]`.
    - If `idx` = `NBANKS`-1: go to ON. Otherwise increment `idx` and go to WAIT.
    - If `good_s[idx]` drops during SETTLE: return to WAIT with the counter cleared (the timeout restarts).
  - ON: `ready` = 1.
    - Any `good_s[i]` = 0 → set `fault`, set `fault_bank` = lowest such i, go to FAULT.
    - `en` = 0 → IDLE.
  - FAULT: all `poc` = 1, `ready` = 0. Stays until `en` = 0, then clears `fault` and goes to IDLE. `fault_bank` holds its value until the next fault.
- In every state, `en` = 0 sets all `poc` = 1 and `ready` = 0 on the next edge. From FAULT, `en` = 0 also clears `fault`; from any other state, `fault` is unchanged.
- Banks already released stay released during WAIT/SETTLE of later banks. If an earlier bank's `good_s` drops before ON is reached, go to FAULT with that bank index.
- Simultaneous events:
  - `en` fall wins over any fault detection in the same cycle.
  - Among simultaneous bad banks, the lowest index is reported.
- Reset mid-operation: asynchronously forces all `poc` = 1, `ready` = 0, `fault` = 0, `fault_bank` = 0, state IDLE.
- Counter width: `$clog2(TIMEOUT+1)`. The counter saturates and never wraps.

## Timing
- Input-to-state latency: 2 cycles (synchroniser) plus 1 registered cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Release of bank i: the cycle after WAIT sees `good_s[i]` is the first SETTLE cycle. `poc[i]` falls `SETTLE` cycles later.
- `ready` rises in the cycle after the last bank's `poc` falls.
- Forcing `poc` back to 1 after `en` fall: 1 cycle. After a `vddio_good` fall: 3 cycles (4 with the filter plus `FILT`-1).

## Configuration
- `ASIC_IOPOC_FILTER_EN` defined: each `good_s[i]` passes through a per-bank glitch filter. The filter output changes only after `FILT` consecutive equal synchronised samples. This adds `FILT` cycles of latency in both directions.
- Macro undefined: `good_s` is the raw synchroniser output. `FILT` is ignored and no filter logic is present.

## Structure
- Package `asic_iopoc_pkg`: state enum (IDLE, WAIT, SETTLE, ON, FAULT) and the width helper functions for the counter and index.
- Sub-module `asic_iopoc_filt`: a single-bit 2-flop synchroniser plus the optional filter, with parameter `FILT`. It is instantiated `NBANKS` times.
- The top level holds the FSM, counter, `idx`, and output registers.

## Test plan
- Reset, then `en` = 1 with `vddio_good` = 4'b1111 from the start (defaults) → `poc` falls bank 0..3 in order, each ~17+ cycles apart; `ready` = 1 after the fourth release; `fault` = 0.
- `en` = 1 with `vddio_good` = 4'b0011 held → banks 0 and 1 released; after 1024 cycles in WAIT(2), `fault` = 1, `fault_bank` = 2, `poc` = 4'b1111, `ready` = 0.
- In ON, drop `vddio_good[3]` and `vddio_good[1]` in the same cycle → `fault_bank` = 1, `poc` = 4'b1111 within 3 cycles. Then `en` = 0 → `fault` = 0, state IDLE.
- In SETTLE(0), pulse `vddio_good[0]` low for 5 cycles → `poc[0]` stays 1; the settle period restarts after good returns; release then completes normally.
- With `ASIC_IOPOC_FILTER_EN` and `FILT` = 4, a 2-cycle low glitch on `vddio_good[2]` in ON → no fault, `ready` stays 1. Without the macro, the same glitch → fault with `fault_bank` = 2.
- Deassert `nreset` while in SETTLE(2) → `poc` = 4'b1111, `ready` = 0, `fault` = 0 immediately (asynchronously); after reset is released, the sequence restarts at bank 0.

Source files
------------

// File: rtl/asic_iopoc_pkg.sv
// Shared types and width helpers for the IO-ring power-on-control sequencer.
package asic_iopoc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SETTLE,
    ST_ON,
    ST_FAULT
  } state_e;

  // Wide enough to hold every value from 0 up to and including the timeout.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  function automatic int idx_width(input int nbanks);
    return (nbanks > 1) ? $clog2(nbanks) : 1;
  endfunction

endpackage

// File: rtl/asic_iopoc_filt.sv
// Single-bit 2-flop synchroniser for one vddio level detector, followed by an
// optional glitch filter compiled in with ASIC_IOPOC_FILTER_EN.
module asic_iopoc_filt #(
  parameter int FILT = 4
) (
  input  logic i_clk,
  input  logic i_nreset,
  input  logic i_async,
  output logic o_good
);

  logic r_meta;
  logic r_sync;

  if (FILT < 1) begin : g_filt_check
    $error("asic_iopoc_filt: FILT must be at least 1");
  end

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

`ifdef ASIC_IOPOC_FILTER_EN
  localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;

  logic [FW-1:0] r_run;
  logic          r_filt;

  // r_run counts consecutive samples that disagree with the current output;
  // the output flips on the FILT-th such sample.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_run  <= '0;
      r_filt <= 1'b0;
    end else if (r_sync == r_filt) begin
      r_run  <= '0;
    end else if (r_run == FW'(FILT - 1)) begin
      r_run  <= '0;
      r_filt <= r_sync;
    end else begin
      r_run  <= r_run + 1'b1;
    end
  end

  assign o_good = r_filt;
`else
  assign o_good = r_sync;
`endif

endmodule

// File: rtl/asic_iopoc_seq.sv
// IO-ring POC sequencer: releases pad banks one at a time once each vddio is
// good and settled. Optional glitch filter: define ASIC_IOPOC_FILTER_EN.
module asic_iopoc_seq
  import asic_iopoc_pkg::*;
#(
  parameter int NBANKS  = 4,
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 1024,
  parameter int FILT    = 4
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic                         en,
  input  logic [NBANKS-1:0]            vddio_good,
  output logic [NBANKS-1:0]            poc,
  output logic                         ready,
  output logic                         fault,
  output logic [idx_width(NBANKS)-1:0] fault_bank
);

  localparam int IW = idx_width(NBANKS);
  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX    = IW'(NBANKS - 1);
  localparam logic [CW-1:0] CNT_SETTLE  = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_TIMEOUT = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  if (NBANKS < 1 || NBANKS > 16 || SETTLE < 1 || TIMEOUT <= SETTLE) begin : g_param_check
    $error("asic_iopoc_seq: illegal NBANKS/SETTLE/TIMEOUT combination");
  end

  function automatic logic [IW-1:0] lowest_set(input logic [NBANKS-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = NBANKS - 1; i >= 0; i--) begin
      if (v[i]) r = IW'(i);
    end
    return r;
  endfunction

  logic [NBANKS-1:0] w_good_s;

  for (genvar g = 0; g < NBANKS; g++) begin : g_bank
    asic_iopoc_filt #(
      .FILT(FILT)
    ) u_filt (
      .i_clk   (clk),
      .i_nreset(nreset),
      .i_async (vddio_good[g]),
      .o_good  (w_good_s[g])
    );
  end

  state_e            r_state;
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_cnt;
  logic [NBANKS-1:0] r_poc;
  logic              r_ready;
  logic              r_fault;
  logic [IW-1:0]     r_fault_bank;

  state_e            w_state_nxt;
  logic [IW-1:0]     w_idx_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [NBANKS-1:0] w_poc_nxt;
  logic              w_ready_nxt;
  logic              w_fault_nxt;
  logic [IW-1:0]     w_fault_bank_nxt;
  logic              w_go_fault;
  logic [IW-1:0]     w_go_fault_idx;

  // A released bank (poc low) whose supply is no longer good is a power loss.
  logic [NBANKS-1:0] w_lost;
  logic              w_cur_good;

  assign w_lost     = ~w_good_s & ~r_poc;
  assign w_cur_good = w_good_s[r_idx];

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_cnt_nxt        = r_cnt;
    w_poc_nxt        = r_poc;
    w_ready_nxt      = 1'b0;
    w_fault_nxt      = r_fault;
    w_fault_bank_nxt = r_fault_bank;
    w_go_fault       = 1'b0;
    w_go_fault_idx   = '0;

    // Dropping en overrides every other event, including a same-cycle fault.
    if (!en) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
      w_poc_nxt   = '1;
      if (r_state == ST_FAULT) w_fault_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_poc_nxt = '1;
          if (!r_fault) begin
            w_state_nxt = ST_WAIT;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
          end
        end

        ST_WAIT: begin
          if (|w_lost) begin
            w_go_fault     = 1'b1;
            w_go_fault_idx = lowest_set(w_lost);
          end else if (w_cur_good) begin
            w_state_nxt = ST_SETTLE;
            w_cnt_nxt   = CNT_SETTLE;
          end else if (r_cnt == CNT_TIMEOUT) begin
            w_go_fault     = 1'b1;
            w_go_fault_idx = r_idx;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end

        ST_SETTLE: begin
          if (|w_lost) begin
            w_go_fault     = 1'b1;
            w_go_fault_idx = lowest_set(w_lost);
          end else if (!w_cur_good) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = '0;
          end else if (r_cnt <= CNT_ONE) begin
            w_cnt_nxt        = '0;
            w_poc_nxt[r_idx] = 1'b0;
            if (r_idx == LAST_IDX) begin
              w_state_nxt = ST_ON;
            end else begin
              w_state_nxt = ST_WAIT;
              w_idx_nxt   = r_idx + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end

        ST_ON: begin
          if (|w_lost) begin
            w_go_fault     = 1'b1;
            w_go_fault_idx = lowest_set(w_lost);
          end else begin
            w_ready_nxt = 1'b1;
          end
        end

        ST_FAULT: begin
          w_poc_nxt = '1;
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_poc_nxt   = '1;
        end
      endcase

      if (w_go_fault) begin
        w_state_nxt      = ST_FAULT;
        w_poc_nxt        = '1;
        w_ready_nxt      = 1'b0;
        w_fault_nxt      = 1'b1;
        w_fault_bank_nxt = w_go_fault_idx;
        w_cnt_nxt        = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_poc        <= '1;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_bank <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_poc        <= w_poc_nxt;
      r_ready      <= w_ready_nxt;
      r_fault      <= w_fault_nxt;
      r_fault_bank <= w_fault_bank_nxt;
    end
  end

  assign poc        = r_poc;
  assign ready      = r_ready;
  assign fault      = r_fault;
  assign fault_bank = r_fault_bank;

endmodule

// File: tb/tb_asic_iopoc_seq.sv
// Self-checking bench for asic_iopoc_seq with default parameters; timings
// shift by FILT when built with ASIC_IOPOC_FILTER_EN.
module tb_asic_iopoc_seq;

  localparam int NB      = 4;
  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 1024;
  localparam int FILT    = 4;
`ifdef ASIC_IOPOC_FILTER_EN
  localparam int OFS = FILT;
`else
  localparam int OFS = 0;
`endif
  // First release: 2 sync cycles + 1 WAIT cycle + SETTLE; then SETTLE+1 per bank.
  localparam int FIRST = 3 + SETTLE + OFS;
  localparam int GAP   = SETTLE + 1;

  logic          clk = 1'b0;
  logic          nreset;
  logic          en;
  logic [NB-1:0] vddio_good;
  logic [NB-1:0] poc;
  logic          ready;
  logic          fault;
  logic [1:0]    fault_bank;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  asic_iopoc_seq #(
    .NBANKS (NB),
    .SETTLE (SETTLE),
    .TIMEOUT(TIMEOUT),
    .FILT   (FILT)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .en        (en),
    .vddio_good(vddio_good),
    .poc       (poc),
    .ready     (ready),
    .fault     (fault),
    .fault_bank(fault_bank)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Release scoreboard: expected {bank, cycle} pushed when stimulus starts,
  // popped whenever a poc bit falls.
  typedef struct {
    int bank;
    int at;
  } rel_t;
  rel_t       rel_q[$];
  bit         sb_on = 1'b0;
  logic [3:0] poc_prev = 4'hF;
  int         last_fall = -1;

  always @(negedge clk) begin
    rel_t e;
    if (sb_on) begin
      for (int i = 0; i < NB; i++) begin
        if (poc_prev[i] && !poc[i]) begin
          if (rel_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_release: bank %0d fell at cycle %0d, want no release", i, cyc);
          end else begin
            e = rel_q.pop_front();
            check("release_bank", i, e.bank);
            check("release_cycle", cyc, e.at);
          end
          last_fall <= cyc;
        end
      end
    end
    poc_prev <= poc;
  end

  typedef struct {
    logic [3:0] vdd;
    int         ncyc;
    logic [3:0] poc;
    logic       rdy;
    logic       flt;
    logic [1:0] fb;
  } vec_t;
  vec_t vecs[5];
  vec_t exp_q[$];

  task automatic start_run(input logic [3:0] vdd, output int c0);
    vddio_good = vdd;
    en = 1'b0;
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    c0 = cyc;
    nreset = 1'b1;
    en = 1'b1;
  endtask

  task automatic push_releases(input int t0);
    rel_t r;
    for (int i = 0; i < NB; i++) begin
      r.bank = i;
      r.at   = t0 + GAP * i;
      rel_q.push_back(r);
    end
  endtask

  task automatic wait_ready(input int maxc, output int waited);
    waited = 0;
    while (!ready && waited < maxc) begin
      @(negedge clk);
      waited++;
    end
  endtask

  initial begin
    int   c0;
    int   w;
    int   t1;
    int   d;
    vec_t v;

    vecs[0] = '{4'b1111, 120,  4'b0000, 1'b1, 1'b0, 2'd0};
    vecs[1] = '{4'b0110, 1200, 4'b1111, 1'b0, 1'b1, 2'd0};
    vecs[2] = '{4'b1101, 1200, 4'b1111, 1'b0, 1'b1, 2'd1};
    vecs[3] = '{4'b1011, 1200, 4'b1111, 1'b0, 1'b1, 2'd2};
    vecs[4] = '{4'b0111, 1200, 4'b1111, 1'b0, 1'b1, 2'd3};

    nreset = 1'b0;
    en = 1'b0;
    vddio_good = '0;
    repeat (2) @(negedge clk);
    check("reset_poc", poc, 4'b1111);
    check("reset_ready", ready, 1'b0);
    check("reset_fault", fault, 1'b0);
    check("reset_fault_bank", fault_bank, 2'd0);

    // Table: final outputs after a fixed run with a constant vddio pattern.
    for (int k = 0; k < 5; k++) begin
      start_run(vecs[k].vdd, c0);
      exp_q.push_back(vecs[k]);
      repeat (vecs[k].ncyc) @(negedge clk);
      v = exp_q.pop_front();
      check("vec_poc", poc, v.poc);
      check("vec_ready", ready, v.rdy);
      check("vec_fault", fault, v.flt);
      check("vec_fault_bank", fault_bank, v.fb);
    end

    // Nominal power-up: order, spacing and ready timing; then en drop.
    start_run(4'b1111, c0);
    push_releases(c0 + FIRST);
    sb_on = 1'b1;
    wait_ready(200, w);
    check("nominal_ready_cycle", cyc, c0 + FIRST + GAP * (NB - 1) + 1);
    check("ready_after_last_release", cyc, last_fall + 1);
    check("nominal_all_released", rel_q.size(), 0);
    check("nominal_fault", fault, 1'b0);
    en = 1'b0;
    @(negedge clk);
    check("en_drop_poc", poc, 4'b1111);
    check("en_drop_ready", ready, 1'b0);
    check("en_drop_fault", fault, 1'b0);
    sb_on = 1'b0;

    // Two banks drop together in ON: lowest index reported, 3-cycle reaction.
    start_run(4'b1111, c0);
    wait_ready(200, w);
    check("on_reached", ready, 1'b1);
    vddio_good = 4'b0101;
    repeat (2 + OFS) @(negedge clk);
    check("drop_not_yet", poc, 4'b0000);
    @(negedge clk);
    check("drop_poc", poc, 4'b1111);
    check("drop_ready", ready, 1'b0);
    check("drop_fault", fault, 1'b1);
    check("drop_fault_bank", fault_bank, 2'd1);
    en = 1'b0;
    @(negedge clk);
    check("fault_clear", fault, 1'b0);
    check("fault_bank_held", fault_bank, 2'd1);
    check("fault_clear_poc", poc, 4'b1111);
    vddio_good = 4'b1111;

    // 5-cycle low on bank 0 during its settle: settle restarts after return.
    start_run(4'b1111, c0);
    push_releases(c0 + 31 + OFS);
    sb_on = 1'b1;
    repeat (7) @(negedge clk);
    vddio_good[0] = 1'b0;
    repeat (5) @(negedge clk);
    vddio_good[0] = 1'b1;
    while (cyc < c0 + FIRST + 1) @(negedge clk);
    check("settle_glitch_held", poc[0], 1'b1);
    wait_ready(200, w);
    check("settle_glitch_ready_cycle", cyc, c0 + 31 + OFS + GAP * (NB - 1) + 1);
    check("settle_glitch_all_released", rel_q.size(), 0);
    check("settle_glitch_fault", fault, 1'b0);
    sb_on = 1'b0;

    // Timeout waiting for bank 2 with banks 0 and 1 already released.
    start_run(4'b0011, c0);
    w = 0;
    while (poc != 4'b1100 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("timeout_pre_poc", poc, 4'b1100);
    t1 = cyc;
    w = 0;
    while (!fault && w < TIMEOUT + 50) begin
      @(negedge clk);
      w++;
    end
    d = cyc - t1;
    n_cmp++;
    if (d < TIMEOUT || d > TIMEOUT + 2) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles, want %0d..%0d", d, TIMEOUT, TIMEOUT + 2);
    end
    check("timeout_fault", fault, 1'b1);
    check("timeout_fault_bank", fault_bank, 2'd2);
    check("timeout_poc", poc, 4'b1111);
    check("timeout_ready", ready, 1'b0);

    // Short glitch on bank 2 in ON: filtered away only with the filter built in.
    start_run(4'b1111, c0);
    wait_ready(200, w);
    check("glitch_on_reached", ready, 1'b1);
    vddio_good[2] = 1'b0;
    repeat (2) @(negedge clk);
    vddio_good[2] = 1'b1;
    repeat (12) @(negedge clk);
`ifdef ASIC_IOPOC_FILTER_EN
    check("glitch_fault", fault, 1'b0);
    check("glitch_ready", ready, 1'b1);
    check("glitch_poc", poc, 4'b0000);
`else
    check("glitch_fault", fault, 1'b1);
    check("glitch_fault_bank", fault_bank, 2'd2);
    check("glitch_ready", ready, 1'b0);
`endif

    // Asynchronous reset during SETTLE(2), then a clean restart from bank 0.
    start_run(4'b1111, c0);
    while (cyc < c0 + FIRST + GAP + 4) @(negedge clk);
    check("mid_settle_poc", poc, 4'b1100);
    nreset = 1'b0;
    #1;
    check("async_reset_poc", poc, 4'b1111);
    check("async_reset_ready", ready, 1'b0);
    check("async_reset_fault", fault, 1'b0);
    @(negedge clk);
    c0 = cyc;
    nreset = 1'b1;
    push_releases(c0 + FIRST);
    sb_on = 1'b1;
    wait_ready(200, w);
    check("restart_ready_cycle", cyc, c0 + FIRST + GAP * (NB - 1) + 1);
    check("restart_all_released", rel_q.size(), 0);
    sb_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
